// File: rtl/cell_row_pkg.sv
// cell_row_pkg: shared types and sizing helpers for the cell row sequencer
package cell_row_pkg;

    localparam int CELL_RAM_BITS = 4;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

    function automatic int slots_of(input int dimx, input int port_width);
        return dimx * CELL_RAM_BITS / port_width;
    endfunction

endpackage

// File: rtl/cell_row_cfg_ctrl_settle_timer.sv
// settle_timer: down-counter that times the settle window of a row run
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt;

    // load SETTLE-1 on run entry, then count down and park at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= CW'(SETTLE - 1);
        else if (en && cnt != '0) cnt <= cnt - CW'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cell_row_cfg_ctrl.sv
// cell_row_cfg_ctrl: loads a cell row's truth tables from a stream, then runs and captures it
module cell_row_cfg_ctrl
    import cell_row_pkg::*;
#(
    parameter int DIMX = 64,
    parameter int PORT_WIDTH = 32,
    parameter int SETTLE = 4,
    localparam int SLOTS = slots_of(DIMX, PORT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PORT_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_last,
    input  logic                    start,
    input  logic [DIMX-1:0]         lin_data,
    output logic [SLOTS-1:0]        we_ram,
    output logic [DIMX*4-1:0]       set_ram,
    output logic [DIMX-1:0]         in_linux,
    input  logic [DIMX-1:0]         row_out,
    output logic [DIMX-1:0]         result,
    output logic                    result_valid,
    output logic                    configured,
    output logic                    busy,
    output logic                    err
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t state, next_state;
    logic [SW-1:0] slot;
    logic accept, last_slot, frame_end, frame_ok, idle, run_go, run_err, done;

    // cfg_ready is only ever high in IDLE/LOAD, so accept implies one of those states
    assign accept    = cfg_valid & cfg_ready;
    assign last_slot = (slot == SW'(SLOTS - 1));
    assign frame_end = accept & (last_slot | cfg_last);
    assign frame_ok  = accept & last_slot & cfg_last;
    assign idle      = (state == IDLE);
    assign run_go    = idle & start & configured & ~accept;
    assign run_err   = idle & start & ~configured & ~accept;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (run_go),
        .en   (state == RUN),
        .done (done)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= next_state;
    end

    // next-state decode; a config word always wins over a same-cycle start
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? (frame_end ? IDLE : LOAD) : (run_go ? RUN : IDLE);
            LOAD:    next_state = frame_end ? IDLE : LOAD;
            RUN:     next_state = done ? CAPTURE : RUN;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // registered outputs, slot counter and RAM image; handshake flags follow the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ready    <= 1'b0;
            we_ram       <= '0;
            set_ram      <= '0;
            slot         <= '0;
            in_linux     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            configured   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            cfg_ready    <= (next_state == IDLE) || (next_state == LOAD);
            busy         <= (next_state != IDLE);
            we_ram       <= '0;
            result_valid <= 1'b0;
            if (accept) begin
                we_ram                                 <= SLOTS'(1) << slot;
                set_ram[slot*PORT_WIDTH +: PORT_WIDTH] <= cfg_data;
                slot                                   <= frame_end ? '0 : slot + SW'(1);
                configured                             <= frame_ok;
                err                                    <= err | (frame_end & ~frame_ok);
            end
            if (run_err) err <= 1'b1;
            if (run_go) in_linux <= lin_data;
            if (state == CAPTURE) begin
                result       <= row_out;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cell_row_cfg_ctrl.sv
// tb_cell_row_cfg_ctrl: directed bench for the cell row config/run sequencer
module tb_cell_row_cfg_ctrl;

    localparam int DIMX = 64;
    localparam int PW = 32;
    localparam int SLOTS = 8;
    localparam int SETTLE = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic cfg_valid = 1'b0, cfg_last = 1'b0, start = 1'b0;
    logic [PW-1:0] cfg_data = '0;
    logic [DIMX-1:0] lin_data = '0;
    logic [DIMX-1:0] row_out;
    logic cfg_ready, result_valid, configured, busy, err;
    logic [SLOTS-1:0] we_ram;
    logic [DIMX*4-1:0] set_ram;
    logic [DIMX-1:0] in_linux, result;

    int n_checks = 0;
    int n_fail = 0;

    cell_row_cfg_ctrl #(.DIMX(DIMX), .PORT_WIDTH(PW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .start(start), .lin_data(lin_data),
        .we_ram(we_ram), .set_ram(set_ram), .in_linux(in_linux), .row_out(row_out),
        .result(result), .result_valid(result_valid), .configured(configured),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // row stand-in: a cell passes its input through only when its table is 4'hF
    always_comb begin
        row_out = '0;
        for (int i = 0; i < DIMX; i++) row_out[i] = in_linux[i] & (&set_ram[4*i +: 4]);
    end

    task automatic send(input logic [PW-1:0] d, input logic l);
        cfg_valid = 1'b1;
        cfg_data = d;
        cfg_last = l;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({we_ram, set_ram, in_linux, result, result_valid, configured, busy, err, cfg_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%h cfg=%b busy=%b err=%b rdy=%b required all 0", we_ram, configured, busy, err, cfg_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got rdy=%b busy=%b required rdy=1 busy=0", cfg_ready, busy);
        end
    endtask

    task automatic test_start_unconfigured();
        start = 1'b1;
        lin_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_unconf got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_unconf_idle cyc=%0d got rv=%b busy=%b required 0 0", c, result_valid, busy);
            end
        end
    endtask

    task automatic test_full_load();
        logic [SLOTS-1:0] exp_we;
        logic [PW-1:0] exp_d;
        for (int k = 0; k < SLOTS; k++) begin
            exp_d = 32'h1111_1111 * k;
            send(exp_d, k == SLOTS - 1);
            exp_we = SLOTS'(1) << k;
            n_checks++;
            if (we_ram !== exp_we || set_ram[k*PW +: PW] !== exp_d) begin
                n_fail++;
                $display("FAIL full_load k=%0d got we=%h slot=%h required we=%h slot=%h", k, we_ram, set_ram[k*PW +: PW], exp_we, exp_d);
            end
        end
        n_checks++;
        if (configured !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_load_done got cfg=%b err=%b busy=%b required 1 0 0", configured, err, busy);
        end
        @(negedge clk);
        n_checks++;
        if (we_ram !== '0) begin
            n_fail++;
            $display("FAIL full_load_we_clear got we=%h required 00", we_ram);
        end
    endtask

    task automatic test_framing();
        for (int k = 0; k < 4; k++) send(32'hDEAD_0000 + PW'(k), k == 3);
        n_checks++;
        if (we_ram !== 8'h08 || set_ram[3*PW +: PW] !== 32'hDEAD_0003) begin
            n_fail++;
            $display("FAIL framing_write got we=%h slot3=%h required we=08 slot3=dead0003", we_ram, set_ram[3*PW +: PW]);
        end
        n_checks++;
        if (err !== 1'b1 || configured !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_flags got err=%b cfg=%b busy=%b required 1 0 0", err, configured, busy);
        end
        for (int k = 0; k < SLOTS; k++) send('1, k == SLOTS - 1);
        n_checks++;
        if (configured !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_reload got cfg=%b err=%b required 1 1", configured, err);
        end
    endtask

    task automatic test_run();
        logic [DIMX-1:0] lin;
        int cyc;
        lin = 64'hA5A5_0000_FFFF_1234;
        start = 1'b1;
        lin_data = lin;
        @(negedge clk);
        start = 1'b0;
        lin_data = '0;
        n_checks++;
        if (in_linux !== lin || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry got in=%h busy=%b required in=%h busy=1", in_linux, busy, lin);
        end
        cyc = 1;
        while (!result_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (result_valid !== 1'b1 || cyc != 6) begin
            n_fail++;
            $display("FAIL run_latency got rv=%b cyc=%0d required rv=1 cyc=6", result_valid, cyc);
        end
        n_checks++;
        if (result !== lin) begin
            n_fail++;
            $display("FAIL run_result got %h required %h", result, lin);
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || in_linux !== lin) begin
            n_fail++;
            $display("FAIL run_after got rv=%b busy=%b in=%h required 0 0 %h", result_valid, busy, in_linux, lin);
        end
    endtask

    task automatic test_collision();
        cfg_valid = 1'b1;
        cfg_data = '1;
        cfg_last = 1'b0;
        start = 1'b1;
        lin_data = 64'h1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b0;
        n_checks++;
        if (we_ram !== 8'h01 || busy !== 1'b1 || configured !== 1'b0 || in_linux !== 64'hA5A5_0000_FFFF_1234) begin
            n_fail++;
            $display("FAIL collision got we=%h busy=%b cfg=%b in=%h required 01 1 0 a5a50000ffff1234", we_ram, busy, configured, in_linux);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_no_run cyc=%0d got rv=%b required 0", c, result_valid);
            end
        end
        for (int k = 1; k < SLOTS; k++) send('1, k == SLOTS - 1);
        n_checks++;
        if (configured !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_reload got cfg=%b required 1", configured);
        end
    endtask

    task automatic test_back_to_back();
        logic [DIMX-1:0] lin;
        int cyc;
        lin = 64'h0123_4567_89AB_CDEF;
        start = 1'b1;
        lin_data = lin;
        @(negedge clk);
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 32'h1234_5678;
        cfg_last = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ready_entry got rdy=%b required 0", cfg_ready);
        end
        cyc = 1;
        while (!result_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (we_ram !== '0 || (!result_valid && cfg_ready !== 1'b0)) begin
                n_fail++;
                $display("FAIL run_blocks_cfg cyc=%0d got we=%h rdy=%b required we=00 rdy=0", cyc, we_ram, cfg_ready);
            end
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (result_valid !== 1'b1 || result !== lin || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_held_cfg got rv=%b res=%h rdy=%b required 1 %h 1", result_valid, result, cfg_ready, lin);
        end
    endtask

    task automatic test_reset_in_load();
        for (int k = 0; k < 4; k++) send(32'h100 + PW'(k), 1'b0);
        cfg_valid = 1'b1;
        cfg_data = 32'h104;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        n_checks++;
        if (we_ram !== 8'h10) begin
            n_fail++;
            $display("FAIL rst_load_pre got we=%h required 10", we_ram);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (we_ram !== '0) begin
            n_fail++;
            $display("FAIL rst_async_we got we=%h required 00", we_ram);
        end
        @(negedge clk);
        n_checks++;
        if ({we_ram, set_ram, in_linux, result, result_valid, configured, busy, err, cfg_ready} !== '0) begin
            n_fail++;
            $display("FAIL rst_load_outputs got we=%h cfg=%b busy=%b err=%b rdy=%b required all 0", we_ram, configured, busy, err, cfg_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        send(32'hCAFE_F00D, 1'b0);
        n_checks++;
        if (we_ram !== 8'h01 || set_ram !== {224'b0, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL rst_load_slot0 got we=%h slot0=%h required 01 cafef00d", we_ram, set_ram[PW-1:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_unconfigured();
        do_reset();
        test_full_load();
        test_framing();
        test_run();
        test_collision();
        test_back_to_back();
        test_reset_in_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
